// File: rtl/snes_pad_responder.sv
// SNES controller emulator: latches the pad on the host strobe and shifts 16
// active-low bits out on host clock rising edges, with both host lines resynchronized to clk.
module snes_pad_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snes_clk,
  input  logic        data_latch,
  input  logic [11:0] buttons,
  output logic        serial_data,
  output logic [11:0] latched_buttons,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t                 state, state_n;
  logic [4:0]             idx, idx_n;
  logic                   serial_n, done_n;
  logic [11:0]            latched_n;
  logic [SYNC_STAGES-1:0] clk_sync, lat_sync;
  logic                   clk_d, lat_d;
  logic                   clk_s, lat_s, clk_rise, lat_rise, lat_fall;
  logic [15:0]            frame_bits;

  // Reset values match the idle line levels so release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      clk_d    <= 1'b1;
      lat_sync <= '0;
      lat_d    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
      clk_d    <= clk_sync[SYNC_STAGES-1];
      lat_sync <= {lat_sync[SYNC_STAGES-2:0], data_latch};
      lat_d    <= lat_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign lat_s      = lat_sync[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_d;
  assign lat_rise   = lat_s & ~lat_d;
  assign lat_fall   = ~lat_s & lat_d;
  assign frame_bits = {4'hF, ~latched_buttons};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      serial_data     <= IDLE_LEVEL;
      latched_buttons <= '0;
      frame_done      <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      serial_data     <= serial_n;
      latched_buttons <= latched_n;
      frame_done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    serial_n  = serial_data;
    latched_n = latched_buttons;
    done_n    = 1'b0;
    // A latch rising edge restarts the frame from any state and beats a coincident clock edge.
    if (lat_rise) begin
      state_n   = LATCH;
      idx_n     = '0;
      latched_n = buttons;
      serial_n  = ~buttons[0];
    end else begin
      case (state)
        IDLE: serial_n = IDLE_LEVEL;
        LATCH: begin
          if (lat_s) begin
            latched_n = buttons;
            serial_n  = ~buttons[0];
          end else if (lat_fall) begin
            state_n = SHIFT;
            idx_n   = '0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            idx_n = idx + 5'd1;
            if (idx == 5'd15) begin
              state_n  = DONE;
              serial_n = 1'b0;
              done_n   = 1'b1;
            end else begin
              serial_n = frame_bits[idx_n[3:0]];
            end
          end
        end
        DONE: serial_n = 1'b0;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench: drives host latch/clock at 6 us bit period and checks the serial stream.
`timescale 1ns/1ps
module tb_snes_pad_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        snes_clk;
  logic        data_latch;
  logic [11:0] buttons;
  logic        serial_data;
  logic [11:0] latched_buttons;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  snes_pad_responder dut (
    .clk             (clk),
    .reset           (reset),
    .snes_clk        (snes_clk),
    .data_latch      (data_latch),
    .buttons         (buttons),
    .serial_data     (serial_data),
    .latched_buttons (latched_buttons),
    .frame_done      (frame_done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [11:0] b, input int k);
    if (k >= 16) return 1'b0;
    if (k >= 12) return 1'b1;
    return ~b[k];
  endfunction

  task automatic do_latch(input logic [11:0] b);
    buttons    = b;
    data_latch = 1'b1;
    #6000;
    chk("latch_hold_bit0", {31'd0, serial_data}, {31'd0, ~b[0]});
    #6000;
    data_latch = 1'b0;
    #3000;
    chk("bit0", {31'd0, serial_data}, {31'd0, ~b[0]});
  endtask

  // Edges first..last; checks the bit holds through the falling half and advances on the rise.
  task automatic run_edges(input logic [11:0] b, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      snes_clk = 1'b0;
      #3000;
      chk($sformatf("fall_hold_%0d", k), {31'd0, serial_data}, {31'd0, exp_bit(b, k - 1)});
      snes_clk = 1'b1;
      #3000;
      chk($sformatf("bit_%0d", k), {31'd0, serial_data}, {31'd0, exp_bit(b, k)});
    end
  endtask

  initial begin
    reset      = 1'b1;
    snes_clk   = 1'b1;
    data_latch = 1'b0;
    buttons    = 12'h000;
    #103;
    chk("rst_serial", {31'd0, serial_data}, 32'd1);
    chk("rst_latched", {20'd0, latched_buttons}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_idx", {27'd0, dut.idx}, 32'd0);
    reset = 1'b0;
    #1000;
    chk("post_rst_idle", {31'd0, serial_data}, 32'd1);

    // Scenario 1: only B pressed
    do_latch(12'h001);
    run_edges(12'h001, 1, 16);
    chk("s1_done_cnt", fd_cnt, 32'd1);

    // Scenario 2
    do_latch(12'hA5C);
    run_edges(12'hA5C, 1, 16);
    chk("s2_latched", {20'd0, latched_buttons}, 32'h0A5C);
    chk("s2_done_cnt", fd_cnt, 32'd2);

    // Scenario 3: live buttons change mid-frame
    do_latch(12'h3C5);
    run_edges(12'h3C5, 1, 3);
    buttons = 12'hFFF;
    run_edges(12'h3C5, 4, 16);
    chk("s3_latched", {20'd0, latched_buttons}, 32'h03C5);
    chk("s3_done_cnt", fd_cnt, 32'd3);

    // Scenario 4: abort after 7 edges
    do_latch(12'h0F0);
    run_edges(12'h0F0, 1, 7);
    do_latch(12'h800);
    chk("s4_abort_no_done", fd_cnt, 32'd3);
    chk("s4_idx_restart", {27'd0, dut.idx}, 32'd0);
    run_edges(12'h800, 1, 16);
    chk("s4_latched", {20'd0, latched_buttons}, 32'h0800);
    chk("s4_done_cnt", fd_cnt, 32'd4);

    // Scenario 5: async reset mid-SHIFT while serial_data is 0
    do_latch(12'hFFF);
    run_edges(12'hFFF, 1, 3);
    reset = 1'b1;
    #1;
    chk("s5_async_serial", {31'd0, serial_data}, 32'd1);
    chk("s5_async_latched", {20'd0, latched_buttons}, 32'd0);
    chk("s5_async_idx", {27'd0, dut.idx}, 32'd0);
    #100;
    reset = 1'b0;
    #99;
    for (int k = 0; k < 5; k++) begin
      snes_clk = 1'b0;
      #3000;
      snes_clk = 1'b1;
      #3000;
      chk($sformatf("s5_idle_%0d", k), {31'd0, serial_data}, 32'd1);
    end
    chk("s5_done_cnt", fd_cnt, 32'd4);

    // Scenario 6: 20 edges after one latch
    do_latch(12'h5A3);
    run_edges(12'h5A3, 1, 20);
    chk("s6_done_cnt", fd_cnt, 32'd5);
    chk("s6_idx_sat", {27'd0, dut.idx}, 32'd16);
    chk("s6_serial_low", {31'd0, serial_data}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snes_pad_responder.md
SNES_PAD_RESPONDER -- requirements
Module: snes_pad_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops in each input synchronizer (minimum 2).
REQ-002 Parameter: IDLE_LEVEL, default 1'b1, serial_data level in IDLE.
REQ-003 Port: clk  input  1  system clock, all state on its rising edge.
REQ-004 Port: reset  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 Port: snes_clk  input  1  host shift clock, asynchronous to clk, idles high.
REQ-006 Port: data_latch  input  1  host latch strobe, asynchronous to clk, active-high.
REQ-007 Port: buttons  input  12  live pad state, 1 = pressed; bit 0 = B, 1 = Y, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right, 8 = A, 9 = X, 10 = L, 11 = R.
REQ-008 Port: serial_data  output  1  registered data line to host, active-low (0 = pressed).
REQ-009 Port: latched_buttons  output  12  snapshot captured at the last latch.
REQ-010 Port: frame_done  output  1  one-cycle pulse when 16 bits have been shifted.

Function
REQ-011 snes_clk and data_latch each pass through a SYNC_STAGES flop chain; edges are detected on the synchronized value against a one-cycle-delayed copy.
REQ-012 Pin-to-serial_data latency: SYNC_STAGES+1 clk cycles (3 at default).
REQ-013 States: IDLE, LATCH, SHIFT, DONE; 2-bit encoding; 5-bit bit index idx.
REQ-014 IDLE: serial_data = IDLE_LEVEL; snes_clk edges ignored; synchronized latch rising edge -> LATCH.
REQ-015 LATCH: every cycle while synchronized latch is high, latched_buttons <= buttons and serial_data <= ~buttons[0]; idx held at 0.
REQ-016 LATCH: synchronized latch falling edge -> SHIFT, idx = 0, latched_buttons frozen, serial_data keeps ~latched_buttons[0].
REQ-017 SHIFT: each synchronized snes_clk rising edge increments idx by 1 and loads serial_data with ~latched_buttons[idx] for idx 1..11, 1 for idx 12..15.
REQ-018 SHIFT: the rising edge that takes idx from 15 to 16 -> DONE, serial_data <= 0, frame_done = 1 for exactly that cycle.
REQ-019 snes_clk falling edges never change state or outputs.
REQ-020 DONE: serial_data held 0; snes_clk edges ignored; idx saturates at 16, no wrap.
REQ-021 Synchronized latch rising edge in SHIFT or DONE aborts the frame -> LATCH the next cycle; no frame_done for the aborted frame.
REQ-022 Latch high and snes_clk rising edge in the same cycle: the latch wins, the clock edge is discarded, idx stays 0.
REQ-023 buttons changes after the latch falling edge do not affect the frame in progress.
REQ-024 Exactly one frame_done per completed 16-edge frame; never asserted in any other state.

Reset
REQ-025 Reset asynchronously forces state = IDLE, idx = 0, serial_data = IDLE_LEVEL, latched_buttons = 0, frame_done = 0.
REQ-026 Reset forces the snes_clk synchronizer and its delayed copy to 1 and the data_latch synchronizer and its delayed copy to 0, so release produces no false edges.
REQ-027 Reset asserted mid-SHIFT: outputs take their reset values immediately, without waiting for a clk edge.
REQ-028 After reset release, the first frame starts only on a fresh latch rising edge.

Verification
REQ-029 Bench stimulus: clk 50 MHz; host at 6 us clock period, 12 us latch.
REQ-030 Scenario 1: buttons=12'h001, full frame -> serial bits 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; then serial_data=0; one frame_done pulse.
REQ-031 Scenario 2: buttons=12'hA5C, full frame -> bits 0..11 equal ~12'hA5C LSB-first, bits 12..15 = 1; latched_buttons=12'hA5C.
REQ-032 Scenario 3: buttons changes to 12'hFFF after the 3rd clock edge -> remaining bits still follow the latched value.
REQ-033 Scenario 4: latch re-pulses after 7 edges -> frame restarts from bit 0, no frame_done, next frame completes normally.
REQ-034 Scenario 5: reset pulse mid-SHIFT -> serial_data=1 asynchronously; snes_clk edges without a latch -> serial_data stays 1.
REQ-035 Scenario 6: 20 clock edges after one latch -> frame_done once at the 16th; serial_data=0 thereafter; idx=16.
